// File: rtl/divider_seq_if.sv
// Operand/result handshake bundle for divider_seq: valid/ready in, valid/ready out.
interface divider_seq_if #(
    parameter int unsigned DATA_WIDTH = 1024
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle through a single
// DATA_WIDTH+1 bit subtractor; divide by zero short-circuits to an all-ones quotient.
module divider_seq #(
    parameter int unsigned DATA_WIDTH = 1024
) (
    input logic          clk,
    input logic          rst_n,
    divider_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_q, w_q_nxt;
    logic [DATA_WIDTH-1:0] r_d, w_d_nxt;
    // R's top bit is provably zero after every step (R < D), so only the low bits are stored.
    logic [DATA_WIDTH-1:0] r_r, w_r_nxt;
    logic [CntW-1:0]       r_cnt, w_cnt_nxt;
    logic                  r_dbz, w_dbz_nxt;

    logic [DATA_WIDTH:0]   w_t;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_ge;

    assign w_t    = {r_r, r_q[DATA_WIDTH-1]};
    assign w_diff = w_t - {1'b0, r_d};
    // T < 2D, so the difference wraps above 2^DATA_WIDTH exactly when T < D.
    assign w_ge   = ~w_diff[DATA_WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_d_nxt     = r_d;
        w_r_nxt     = r_r;
        w_cnt_nxt   = r_cnt;
        w_dbz_nxt   = r_dbz;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_q_nxt   = bus.dividend;
                    w_d_nxt   = bus.divisor;
                    w_r_nxt   = '0;
                    w_cnt_nxt = '0;
                    if (bus.divisor == '0) begin
                        w_q_nxt     = '1;
                        w_r_nxt     = bus.dividend;
                        w_dbz_nxt   = 1'b1;
                        w_state_nxt = StDone;
                    end else begin
                        w_dbz_nxt   = 1'b0;
                        w_state_nxt = StCalc;
                    end
                end
            end
            StCalc: begin
                w_r_nxt   = w_ge ? w_diff[DATA_WIDTH-1:0] : w_t[DATA_WIDTH-1:0];
                w_q_nxt   = {r_q[DATA_WIDTH-2:0], w_ge};
                w_cnt_nxt = r_cnt + CntW'(1);
                if (r_cnt == CntW'(DATA_WIDTH - 1)) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_d     <= w_d_nxt;
            r_r     <= w_r_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dbz   <= w_dbz_nxt;
        end
    end

    assign bus.in_ready    = (r_state == StIdle) && rst_n;
    assign bus.out_valid   = (r_state == StDone);
    assign bus.quotient    = r_q;
    assign bus.remainder   = r_r;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: directed cases on an 8-bit instance, random traffic on a 1024-bit
// instance, both checked every cycle against a cycle-level arithmetic model.
module tb_divider_seq;
    localparam int unsigned W0    = 8;
    localparam int unsigned W1    = 1024;
    localparam int          NRAND = 14;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    bit   run_b;

    divider_seq_if #(.DATA_WIDTH(W0)) ifa ();
    divider_seq_if #(.DATA_WIDTH(W1)) ifb ();

    divider_seq #(.DATA_WIDTH(W0)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    divider_seq #(.DATA_WIDTH(W1)) u_dut1024 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [W1-1:0] act, input logic [W1-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (low 96 bits) at %0t",
                     name, act[95:0], exp[95:0], $time);
        end
    endtask

    function automatic logic [W1-1:0] rand_words(input int words);
        logic [W1-1:0] v;
        v = '0;
        for (int i = 0; i < words; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Model: per unit, an outstanding result appears a fixed number of edges after accept
    // and stays until the consumer takes it.
    logic [W1-1:0] m_n[2], m_d[2], m_q[2], m_r[2];
    bit            m_z[2], m_busy[2];
    int            m_left[2];
    int            n_xfer[2];

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_busy[u] = 0;
            n_xfer[u] = 0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                logic          v_iv, v_ir, v_ov, v_or, v_z, e_v, e_ir;
                logic [W1-1:0] v_n, v_d, v_q, v_r;
                logic [2*W1-1:0] prod;
                string         tag;
                tag = (u == 0) ? "u8" : "u1024";
                if (u == 0) begin
                    v_iv = ifa.in_valid;  v_ir = ifa.in_ready;  v_ov = ifa.out_valid;
                    v_or = ifa.out_ready; v_z = ifa.div_by_zero;
                    v_n = W1'(ifa.dividend); v_d = W1'(ifa.divisor);
                    v_q = W1'(ifa.quotient); v_r = W1'(ifa.remainder);
                end else begin
                    v_iv = ifb.in_valid;  v_ir = ifb.in_ready;  v_ov = ifb.out_valid;
                    v_or = ifb.out_ready; v_z = ifb.div_by_zero;
                    v_n = ifb.dividend; v_d = ifb.divisor;
                    v_q = ifb.quotient; v_r = ifb.remainder;
                end
                e_v  = m_busy[u] && (m_left[u] == 0);
                e_ir = !m_busy[u] && rst_n;
                cmp({tag, " in_ready"}, W1'(v_ir), W1'(e_ir));
                cmp({tag, " out_valid"}, W1'(v_ov), W1'(e_v));
                if (e_v && v_ov) begin
                    cmp({tag, " quotient"}, v_q, m_q[u]);
                    cmp({tag, " remainder"}, v_r, m_r[u]);
                    cmp({tag, " div_by_zero"}, W1'(v_z), W1'(m_z[u]));
                    if (u == 1 && !m_z[u] && v_or) begin
                        prod = {{W1{1'b0}}, v_q} * {{W1{1'b0}}, m_d[u]} + {{W1{1'b0}}, v_r};
                        cmp("u1024 q*d+r==n", W1'(prod == {{W1{1'b0}}, m_n[u]}), W1'(1));
                        cmp("u1024 r<d", W1'(v_r < m_d[u]), W1'(1));
                    end
                end
                if (!rst_n) begin
                    m_busy[u] = 0;
                end else if (e_v) begin
                    if (v_or) begin
                        m_busy[u] = 0;
                        n_xfer[u]++;
                    end
                end else if (m_busy[u]) begin
                    m_left[u]--;
                end else if (v_iv) begin
                    m_busy[u] = 1;
                    m_n[u]    = v_n;
                    m_d[u]    = v_d;
                    if (v_d == '0) begin
                        m_q[u]    = (u == 0) ? W1'({W0{1'b1}}) : {W1{1'b1}};
                        m_r[u]    = v_n;
                        m_z[u]    = 1;
                        m_left[u] = 0;
                    end else begin
                        m_q[u]    = v_n / v_d;
                        m_r[u]    = v_n % v_d;
                        m_z[u]    = 0;
                        m_left[u] = (u == 0) ? int'(W0) : int'(W1);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        ifb.out_ready = run_b ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic accept0(input logic [7:0] n, input logic [7:0] d);
        bit ok;
        ok = 0;
        ifa.dividend = n;
        ifa.divisor  = d;
        ifa.in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifa.in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        cmp("u8 accept", W1'(ok), W1'(1));
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic run0(input logic [7:0] n, input logic [7:0] d, output logic [7:0] q,
                        output logic [7:0] r, output logic z, output int e);
        accept0(n, d);
        e = 0;
        while (e < 40) begin
            @(negedge clk);
            if (ifa.out_valid) break;
            @(posedge clk);
            #1;
            e++;
        end
        q = ifa.quotient;
        r = ifa.remainder;
        z = ifa.div_by_zero;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q, r;
        logic       z;
        int         e;
        bit         ok;
        logic [7:0] tn[4] = '{8'd5, 8'd255, 8'd255, 8'd0};
        logic [7:0] td[4] = '{8'd9, 8'd1, 8'd255, 8'd13};
        logic [7:0] tq[4] = '{8'd0, 8'd255, 8'd1, 8'd0};
        logic [7:0] tr[4] = '{8'd5, 8'd0, 8'd0, 8'd0};
        n_vec = 0;
        n_err = 0;
        run_b = 0;
        rst_n = 1'b0;
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; ifa.dividend = '0; ifa.divisor = '0;
        ifb.in_valid = 1'b0; ifb.dividend = '0; ifb.divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("reset in_ready", W1'(ifa.in_ready), W1'(0));
        cmp("reset out_valid", W1'(ifa.out_valid), W1'(0));
        cmp("reset quotient", W1'(ifa.quotient), W1'(0));
        cmp("reset remainder", W1'(ifa.remainder), W1'(0));
        cmp("reset div_by_zero", W1'(ifa.div_by_zero), W1'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        cmp("in_ready after reset", W1'(ifa.in_ready), W1'(1));
        @(posedge clk);
        #1;

        // Basic divide
        run0(8'd200, 8'd7, q, r, z, e);
        cmp("t1 latency", W1'(e), W1'(8));
        cmp("t1 quotient", W1'(q), W1'(28));
        cmp("t1 remainder", W1'(r), W1'(4));
        cmp("t1 div_by_zero", W1'(z), W1'(0));
        @(negedge clk);
        cmp("t1 in_ready after xfer", W1'(ifa.in_ready), W1'(1));
        cmp("t1 out_valid after xfer", W1'(ifa.out_valid), W1'(0));
        @(posedge clk);
        #1;

        // Boundary values
        for (int i = 0; i < 4; i++) begin
            run0(tn[i], td[i], q, r, z, e);
            cmp($sformatf("t2[%0d] quotient", i), W1'(q), W1'(tq[i]));
            cmp($sformatf("t2[%0d] remainder", i), W1'(r), W1'(tr[i]));
        end

        // Divide by zero
        run0(8'h5A, 8'h00, q, r, z, e);
        cmp("t3 latency", W1'(e), W1'(0));
        cmp("t3 quotient", W1'(q), W1'(8'hFF));
        cmp("t3 remainder", W1'(r), W1'(8'h5A));
        cmp("t3 div_by_zero", W1'(z), W1'(1));

        // Backpressure with an ignored in_valid pulse while the result is held
        ifa.out_ready = 1'b0;
        run0(8'd100, 8'd3, q, r, z, e);
        cmp("t4 quotient", W1'(q), W1'(33));
        cmp("t4 remainder", W1'(r), W1'(1));
        for (int k = 0; k < 4; k++) begin
            ifa.in_valid = (k == 1);
            ifa.dividend = 8'd9;
            ifa.divisor  = 8'd2;
            @(negedge clk);
            cmp("t4 held quotient", W1'(ifa.quotient), W1'(33));
            cmp("t4 held remainder", W1'(ifa.remainder), W1'(1));
            cmp("t4 held in_ready", W1'(ifa.in_ready), W1'(0));
            @(posedge clk);
            #1;
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        cmp("t4 out_valid after xfer", W1'(ifa.out_valid), W1'(0));
        cmp("t4 in_ready after xfer", W1'(ifa.in_ready), W1'(1));
        @(posedge clk);
        #1;

        // Reset in the middle of CALC
        accept0(8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        cmp("t5 out_valid", W1'(ifa.out_valid), W1'(0));
        cmp("t5 quotient", W1'(ifa.quotient), W1'(0));
        cmp("t5 remainder", W1'(ifa.remainder), W1'(0));
        cmp("t5 in_ready", W1'(ifa.in_ready), W1'(1));
        @(posedge clk);
        #1;
        run0(8'd50, 8'd6, q, r, z, e);
        cmp("t5 new quotient", W1'(q), W1'(8));
        cmp("t5 new remainder", W1'(r), W1'(2));

        // Random back-to-back traffic on the full-width instance
        run_b = 1;
        for (int i = 0; i < NRAND; i++) begin
            logic [W1-1:0] n, d;
            unique case (i % 5)
                0: begin n = rand_words(32); d = rand_words(32); end
                1: begin n = rand_words(32); d = rand_words(2);  end
                2: begin n = rand_words(32); d = W1'(1);         end
                3: begin n = rand_words(4);  d = rand_words(32); end
                default: begin n = rand_words(32); d = rand_words(31); end
            endcase
            if (d == '0) d = W1'(3);
            if (i == 7) d = '0;
            ifb.dividend = n;
            ifb.divisor  = d;
            ifb.in_valid = 1'b1;
            ok = 0;
            for (int k = 0; k < 3000; k++) begin
                @(negedge clk);
                if (ifb.in_ready) begin
                    ok = 1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            cmp("u1024 accept", W1'(ok), W1'(1));
            @(posedge clk);
            #1;
        end
        ifb.in_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (ifb.in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        cmp("u1024 drain", W1'(ok), W1'(1));
        cmp("u8 results delivered", W1'(n_xfer[0]), W1'(8));
        cmp("u1024 results delivered", W1'(n_xfer[1]), W1'(NRAND));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/divider_seq.md
# divider_seq

Sequential unsigned restoring divider: accepts a DATA_WIDTH-bit dividend and divisor over a valid/ready handshake and returns quotient and remainder after one iteration per bit. It is the inverse companion of the wide multiplier datapath. It sits beside the multiplier in the big-integer arithmetic path, for modular reduction and for checking products. Area is traded for latency: there is one subtractor of width DATA_WIDTH+1, and no parallel sub-units.

## Interface
- DATA_WIDTH, 1024, operand width in bits; must be ≥ 2.
- clk  in  1  the single clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- in_valid  in  1  the dividend and divisor are valid.
- in_ready  out  1  the block can accept an operand pair.
- dividend  in  DATA_WIDTH  unsigned dividend.
- divisor  in  DATA_WIDTH  unsigned divisor.
- out_valid  out  1  the result is valid.
- out_ready  in  1  the consumer accepts the result.
- quotient  out  DATA_WIDTH  unsigned quotient.
- remainder  out  DATA_WIDTH  unsigned remainder.
- div_by_zero  out  1  set with the result when divisor was 0.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- in_ready = (state == IDLE) && rst_n. It is combinational from state, and no input register exists beyond the working registers.
- Accept: in_valid && in_ready at a rising edge.
  - Capture dividend into the quotient shift register Q.
  - Capture divisor into D.
  - Clear the partial remainder R (DATA_WIDTH+1 bits).
  - Clear the bit counter cnt (width $clog2(DATA_WIDTH)+1).
- Accept with divisor == 0: go directly to DONE.
  - quotient = all ones.
  - remainder = dividend.
  - div_by_zero = 1.
- Accept with divisor != 0: go to CALC, with div_by_zero = 0.
- Each CALC cycle (restoring step):
  - T = {R[DATA_WIDTH-1:0], Q[DATA_WIDTH-1]}.
  - If T ≥ {1'b0, D}: R ← T − D and Q ← {Q[DATA_WIDTH-2:0], 1'b1}.
  - Otherwise: R ← T and Q ← {Q[DATA_WIDTH-2:0], 1'b0}.
  - cnt ← cnt + 1.
- On the CALC step where cnt == DATA_WIDTH−1, the step completes and the state moves to DONE.
- In DONE: quotient = Q and remainder = R[DATA_WIDTH-1:0]. R[DATA_WIDTH] is always 0 after a step.
- In DONE: out_valid = 1. quotient, remainder and div_by_zero hold constant until out_valid && out_ready at an edge. After that edge the state is IDLE.
- in_valid is ignored in CALC and DONE. There is no overlap of input and output transactions.
- Arithmetic is unsigned only. The required invariant is dividend = quotient·divisor + remainder, with remainder < divisor, for divisor != 0.

## Timing
- Reset values, on any rising edge with rst_n = 0:
  - state = IDLE.
  - out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0.
  - cnt = 0, R = 0, Q = 0, D = 0.
- in_ready is 0 while rst_n = 0 and 1 in the first cycle after rst_n returns high.
- Reset mid-CALC or mid-DONE abandons the operation. No result is emitted, and the outputs take their reset values at that edge.
- Latency for a normal divide:
  - Accept at edge E0.
  - out_valid is high in the cycle following edge E0+DATA_WIDTH.
  - Latency is DATA_WIDTH cycles.
- Latency for divide by zero: out_valid is high in the cycle following E0 (1 cycle).
- Output handshake:
  - The result transfers at the edge where out_valid && out_ready.
  - out_valid is 0 in the next cycle and in_ready is 1 in that same cycle.
  - out_ready high before out_valid has no effect.
- Maximum throughput is one divide per DATA_WIDTH+2 cycles (accept, DATA_WIDTH steps, drain).
- No output changes while out_valid = 1 and out_ready = 0.

## Test plan
Tests 1–6 run with DATA_WIDTH = 8 unless noted.

1. Basic divide: dividend = 200, divisor = 7, out_ready held 1.
   - out_valid goes high exactly 8 cycles after accept.
   - quotient = 28, remainder = 4, div_by_zero = 0.
   - in_ready is high in the following cycle.
2. Boundary values:
   - 5/9 → quotient 0, remainder 5.
   - 255/1 → quotient 255, remainder 0.
   - 255/255 → quotient 1, remainder 0.
   - 0/13 → quotient 0, remainder 0.
3. Divide by zero: dividend = 0x5A, divisor = 0.
   - out_valid high in the cycle after accept.
   - quotient = 0xFF, remainder = 0x5A, div_by_zero = 1.
4. Backpressure: 100/3 with out_ready low for 5 cycles after out_valid rises.
   - quotient = 33 and remainder = 1 stay stable throughout.
   - in_ready stays 0; a new in_valid pulse during this time is ignored.
   - After out_ready is raised, the transfer happens on one edge.
5. Reset mid-operation: accept 200/7, then drop rst_n for one edge at cycle 4 of CALC.
   - out_valid = 0, quotient = 0, remainder = 0, in_ready = 1 after release.
   - A new 50/6 then yields quotient 8, remainder 2.
6. Default DATA_WIDTH = 1024: back-to-back random operands with random out_ready, including divisor > dividend and divisor = 1.
   - Every result satisfies q·d + r = n and r < d, checked against a scoreboard.
   - Latency is 1024 cycles.
